// File: rtl/seq_divider_if.sv
// Handshake and result bundle for the iterative unsigned divider.
// The requester uses the master view and the divider uses the slave view.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Result obeys dividend == quotient*divisor + remainder with remainder < divisor.
// A zero divisor reports quotient all-ones, remainder = dividend, div_by_zero = 1.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] part_r;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] dvs;
    logic             dz_pend;

    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;

    logic [WIDTH:0]   sh_r;
    logic [WIDTH:0]   trial;
    logic             neg;
    logic [WIDTH-1:0] nxt_r;
    logic [WIDTH-1:0] nxt_q;

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;

    // One restoring step: shift {R,Q} left, trial-subtract at WIDTH+1 bits.
    always_comb begin
        sh_r  = {part_r, part_q[WIDTH-1]};
        trial = sh_r - {1'b0, dvs};
        neg   = trial[WIDTH];
        nxt_q = {part_q[WIDTH-2:0], ~neg};
        nxt_r = neg ? sh_r[WIDTH-1:0] : trial[WIDTH-1:0];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            part_r  <= '0;
            part_q  <= '0;
            dvs     <= '0;
            dz_pend <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        part_r  <= '0;
                        part_q  <= bus.dividend;
                        dvs     <= bus.divisor;
                        ready_q <= 1'b0;
                        state   <= RUN;
                        // Zero divisor takes a single pass through RUN so
                        // done appears one cycle after the start edge.
                        if (bus.divisor == '0) begin
                            dz_pend <= 1'b1;
                            cnt     <= CW'(1);
                        end else begin
                            dz_pend <= 1'b0;
                            cnt     <= CW'(WIDTH);
                        end
                    end
                end
                RUN: begin
                    if (dz_pend) begin
                        quo_q  <= '1;
                        rem_q  <= part_q;
                        dz_q   <= 1'b1;
                        done_q <= 1'b1;
                        cnt    <= '0;
                        state  <= DONE;
                    end else begin
                        part_r <= nxt_r;
                        part_q <= nxt_q;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            quo_q  <= nxt_q;
                            rem_q  <= nxt_r;
                            dz_q   <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against plain / and % arithmetic.
module tb_seq_divider;
    localparam int W = 8;
    localparam int NRAND = 2000;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   accepted;
    int   dones;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one division at the next edge and verify latency, pulse and result.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inject);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           lat;
        bit           got;
        bit           rdy_hi;
        int           done_cyc;
        if (b == 0) begin
            eq = {W{1'b1}}; er = a; edz = 1'b1; lat = 1;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; lat = W;
        end
        check("ready_before_start", bus.ready, 1);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        accepted++;
        got = 0; rdy_hi = 0; done_cyc = 0;
        for (int i = 1; i <= 4 * W; i++) begin
            if (i == inject) begin
                bus.start = 1'b1; bus.dividend = 9; bus.divisor = 9;
            end else begin
                bus.start = 1'b0; bus.dividend = W'($urandom); bus.divisor = W'($urandom);
            end
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                got = 1; done_cyc = i;
                break;
            end
            if (bus.ready !== 1'b0) rdy_hi = 1;
        end
        bus.start = 1'b0;
        check("done_seen", 32'(got), 1);
        check("latency", done_cyc, lat);
        check("quotient", bus.quotient, eq);
        check("remainder", bus.remainder, er);
        check("div_by_zero", bus.div_by_zero, edz);
        check("ready_in_done", bus.ready, 0);
        check("ready_low_in_run", 32'(rdy_hi), 0);
        if (got) dones++;
        @(posedge clk); #1;
        check("done_one_cycle", bus.done, 0);
        check("ready_after_done", bus.ready, 1);
        check("result_held", bus.quotient, eq);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           saw_done;
        tests = 0; fails = 0; accepted = 0; dones = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", bus.ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dz", bus.div_by_zero, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_div(8'd100, 8'd7, 0);
        run_div(8'd255, 8'd1, 0);
        run_div(8'd255, 8'd255, 0);
        run_div(8'd5, 8'd9, 0);
        run_div(8'd0, 8'd3, 0);
        run_div(8'd37, 8'd0, 0);
        run_div(8'd37, 8'd5, 0);
        run_div(8'd200, 8'd3, 3);
        run_div(8'd200, 8'd128, 0);
        run_div(8'd255, 8'd254, 0);

        // Abort a running division with reset.
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) saw_done = 1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_no_done", 32'(saw_done), 0);
        check("abort_done", bus.done, 0);
        check("abort_ready", bus.ready, 1);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_dz", bus.div_by_zero, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) saw_done = 1;
        end
        check("abort_no_late_done", 32'(saw_done), 0);
        run_div(8'd50, 8'd6, 0);

        // Back-to-back random operands, occasionally zero or extreme.
        for (int n = 0; n < NRAND; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 15))
                0:       rb = '0;
                1:       rb = {W{1'b1}};
                2:       rb = W'(1);
                default: rb = W'($urandom);
            endcase
            run_div(ra, rb, 0);
        end
        check("done_count", dones, accepted);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
